subpel_sad_accum: RTL
=====================

# subpel_sad_accum

Pipelined, parametrised successor to the single-row horizontal sub-pixel SAD stage of the motion-estimation path. Accepts one row of filter/reference pixels per cycle over a valid/ready handshake, computes five horizontal candidate SADs per row (left half, left quarter, full, right quarter, right half) using linear interpolation, and accumulates them over all rows of a block. At block end it emits the five block SADs, the winning candidate index and the row count. It sits between the row fetcher and the motion-vector decision logic.

## Interface
- N_PIX, 8: pixels per row (≥3); SAD uses interior pixels 1..N_PIX-2
- PIX_W, 8: bits per pixel
- ACC_W, 16: width of each accumulated block SAD (saturating)
- MAX_ROWS, 16: rows after which a block is force-closed
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  row pixels valid
- in_ready  out  1  block can accept a row
- in_last  in  1  accepted row is the last row of the block
- filter_pix  in  N_PIX*PIX_W  candidate row; pixel i at bits [i*PIX_W +: PIX_W]
- ref_pix  in  N_PIX*PIX_W  reference row, same packing
- sad_valid  out  1  result held on outputs
- sad_ready  in  1  consumer takes result
- sad  out  5*ACC_W  block SADs; slot k at [k*ACC_W +: ACC_W]: 0 left half, 1 left quarter, 2 full, 3 right quarter, 4 right half
- best_idx  out  3  slot of minimum SAD
- best_sad  out  ACC_W  value of that minimum
- rows  out  clog2(MAX_ROWS+1)  rows accumulated in the block

## Operation
- Row accepted when in_valid && in_ready.
- Per interior pixel i (F = filter, R = ref), unsigned floor arithmetic, sums computed at PIX_W+2 bits before shifting:
  - LH = (F[i-1]+F[i])>>1
  - LQ = (F[i-1]+3F[i])>>2
  - FP = F[i]
  - RQ = (3F[i]+F[i+1])>>2
  - RH = (F[i]+F[i+1])>>1
- Abs diff |cand − R[i]| is PIX_W bits. Row SAD per slot = sum over N_PIX−2 diffs, width PIX_W+clog2(N_PIX−2), no loss.
- Accumulator per slot: acc += row SAD, saturating at 2^ACC_W−1; never wraps.
- Row counter increments per row reaching stage 3.
- The block closes on the row carrying in_last, or on the row that brings the counter to MAX_ROWS. On close, final values load into the output register, and accumulators and counter clear in the same edge, so the next row starts a new block with no bubble.
- best_idx: minimum of the five final SADs; ties resolved in priority full (2), then 0, 1, 3, 4. Registered with sad.
- Pipeline states per stage: empty/occupied (valid bit). Output register states: IDLE (sad_valid=0), HOLD (sad_valid=1). IDLE→HOLD on block close. HOLD→IDLE on sad_ready unless a new close occurs in the same cycle (then stays HOLD with new data).

## Timing
- Three stages: S1 registers interpolated abs diffs; S2 registers row SADs; S3 accumulates/loads output.
- Last row accepted at edge k → sad_valid high after edge k+3.
- Global stall: stall = sad_valid && !sad_ready && (S3 would close a block). More simply, all stages advance iff !(sad_valid && !sad_ready). in_ready equals that advance enable (combinational).
- While stalled: all pipeline registers, sad, best_idx, best_sad and rows hold stable.
- Throughput: one row per cycle when sad_ready is held high.
- Reset (any time, including mid-block or in HOLD): next edge clears stage valids, accumulators, counter, and output register. Results: sad_valid=0, sad=0, best_idx=2, best_sad=0, rows=0, in_ready=1. Any partial block is discarded.
- in_last on a row that also hits MAX_ROWS: a single close.

## Test plan
- N_PIX=8, one row with all pixels 0x40 in both inputs, in_last=1 → 3 cycles later sad all 0, best_idx=2, rows=1.
- One row F[i]=4i, R[i]=4i+2, in_last=1 → sad slots 0..4 = 24,18,12,6,0; best_idx=4, best_sad=0.
- Same row ×4 back-to-back, in_last on 4th, then a 1-row block immediately → first result 96,72,48,24,0 rows=4, next result rows=1 on the following cycle, no bubble.
- ACC_W=10: two rows F=0xFF, R=0x00 → all slots saturate to 1023, best_idx=2, best_sad=1023.
- sad_ready low, send two 1-row blocks → first result stable, in_ready falls, second block stalls in pipe; raising sad_ready → second result appears 1 cycle after the handshake, no data lost.
- rst pulse during row 2 of a 3-row block → outputs return to reset values; the following 1-row block reports rows=1 with correct sums.

Source files
------------

// File: rtl/subpel_sad_accum.sv
// subpel_sad_accum: horizontal sub-pixel SAD accumulator for the motion-estimation path.
// Each accepted row is captured, turned into five interpolated absolute-difference sets,
// reduced to five row SADs, and accumulated per block. When a block closes, the five
// block SADs, the winning candidate and the row count are held for the decision logic.
// Candidate slots: 0 left half, 1 left quarter, 2 full, 3 right quarter, 4 right half.
module subpel_sad_accum #(
   parameter int N_PIX    = 8,
   parameter int PIX_W    = 8,
   parameter int ACC_W    = 16,
   parameter int MAX_ROWS = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_last,
   input  logic [N_PIX*PIX_W-1:0]           filter_pix,
   input  logic [N_PIX*PIX_W-1:0]           ref_pix,
   output logic                             sad_valid,
   input  logic                             sad_ready,
   output logic [5*ACC_W-1:0]               sad,
   output logic [2:0]                       best_idx,
   output logic [ACC_W-1:0]                 best_sad,
   output logic [$clog2(MAX_ROWS+1)-1:0]    rows
);

   localparam int NI    = N_PIX - 2;
   localparam int IW    = PIX_W + 2;
   localparam int RS_W  = PIX_W + $clog2(NI);
   localparam int RW    = $clog2(MAX_ROWS + 1);
   localparam int SUM_W = ((ACC_W > RS_W) ? ACC_W : RS_W) + 1;

   typedef enum logic {
      OUT_IDLE,
      OUT_HOLD
   } out_state_t;

   out_state_t out_state, out_state_next;

   logic adv;

   logic                   s0_valid, s0_last;
   logic [N_PIX*PIX_W-1:0] s0_f, s0_r;

   logic [IW-1:0]          pa, pb, pc;
   logic [PIX_W-1:0]       pr;
   logic [PIX_W-1:0]       cand   [5];
   logic [PIX_W-1:0]       diff_c [5][NI];

   logic                   s1_valid, s1_last;
   logic [PIX_W-1:0]       s1_diff [5][NI];

   logic [RS_W-1:0]        rs_c [5];
   logic                   s2_valid, s2_last;
   logic [RS_W-1:0]        s2_sad [5];

   logic [ACC_W-1:0]       acc [5];
   logic [RW-1:0]          rows_cnt;
   logic [SUM_W-1:0]       sum_c [5];
   logic [ACC_W-1:0]       new_acc [5];
   logic [RW-1:0]          new_rows;
   logic                   closing;
   logic [2:0]             best_i_c;
   logic [ACC_W-1:0]       best_v_c;

   // The whole pipeline moves together; only a held, unconsumed result can stop it.
   assign sad_valid = (out_state == OUT_HOLD);
   assign adv       = !(sad_valid && !sad_ready);
   assign in_ready  = adv;

   // Capture the incoming row so interpolation works from registered pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid <= 1'b0;
      end else if (adv) begin
         s0_valid <= in_valid;
         s0_last  <= in_last;
         s0_f     <= filter_pix;
         s0_r     <= ref_pix;
      end
   end

   // Interpolate the five candidates per interior pixel and take |cand - ref|.
   always_comb begin
      pa = '0;
      pb = '0;
      pc = '0;
      pr = '0;
      for (int k = 0; k < 5; k++) begin
         cand[k] = '0;
         for (int j = 0; j < NI; j++) begin
            diff_c[k][j] = '0;
         end
      end
      for (int j = 0; j < NI; j++) begin
         pa = IW'(s0_f[j*PIX_W +: PIX_W]);
         pb = IW'(s0_f[(j+1)*PIX_W +: PIX_W]);
         pc = IW'(s0_f[(j+2)*PIX_W +: PIX_W]);
         pr = s0_r[(j+1)*PIX_W +: PIX_W];
         cand[0] = PIX_W'((pa + pb) >> 1);
         cand[1] = PIX_W'((pa + pb + (pb << 1)) >> 2);
         cand[2] = pb[PIX_W-1:0];
         cand[3] = PIX_W'((pb + (pb << 1) + pc) >> 2);
         cand[4] = PIX_W'((pb + pc) >> 1);
         for (int k = 0; k < 5; k++) begin
            diff_c[k][j] = (cand[k] >= pr) ? (cand[k] - pr) : (pr - cand[k]);
         end
      end
   end

   // Stage 1 register: absolute differences for every candidate and interior pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= s0_valid;
         s1_last  <= s0_last;
         s1_diff  <= diff_c;
      end
   end

   // Sum the differences of each candidate across the row at full precision.
   always_comb begin
      for (int k = 0; k < 5; k++) begin
         rs_c[k] = '0;
         for (int j = 0; j < NI; j++) begin
            rs_c[k] = rs_c[k] + RS_W'(s1_diff[k][j]);
         end
      end
   end

   // Stage 2 register: the five row SADs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_sad   <= rs_c;
      end
   end

   // Saturating block totals, next row count, close decision and winner selection.
   always_comb begin
      for (int k = 0; k < 5; k++) begin
         sum_c[k]   = SUM_W'(acc[k]) + SUM_W'(s2_sad[k]);
         new_acc[k] = (|sum_c[k][SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum_c[k][ACC_W-1:0];
      end
      new_rows = rows_cnt + RW'(1);
      closing  = s2_valid && (s2_last || (new_rows == RW'(MAX_ROWS)));
      best_i_c = 3'd2;
      best_v_c = new_acc[2];
      if (new_acc[0] < best_v_c) begin
         best_i_c = 3'd0;
         best_v_c = new_acc[0];
      end
      if (new_acc[1] < best_v_c) begin
         best_i_c = 3'd1;
         best_v_c = new_acc[1];
      end
      if (new_acc[3] < best_v_c) begin
         best_i_c = 3'd3;
         best_v_c = new_acc[3];
      end
      if (new_acc[4] < best_v_c) begin
         best_i_c = 3'd4;
         best_v_c = new_acc[4];
      end
   end

   // Stage 3 accumulators: clear on close so the next row starts a fresh block.
   always_ff @(posedge clk) begin
      if (rst) begin
         rows_cnt <= '0;
         for (int k = 0; k < 5; k++) begin
            acc[k] <= '0;
         end
      end else if (adv && s2_valid) begin
         if (closing) begin
            rows_cnt <= '0;
            for (int k = 0; k < 5; k++) begin
               acc[k] <= '0;
            end
         end else begin
            rows_cnt <= new_rows;
            acc      <= new_acc;
         end
      end
   end

   // Result register: loads the final block values when a block closes.
   always_ff @(posedge clk) begin
      if (rst) begin
         sad      <= '0;
         best_idx <= 3'd2;
         best_sad <= '0;
         rows     <= '0;
      end else if (adv && closing) begin
         for (int k = 0; k < 5; k++) begin
            sad[k*ACC_W +: ACC_W] <= new_acc[k];
         end
         best_idx <= best_i_c;
         best_sad <= best_v_c;
         rows     <= new_rows;
      end
   end

   // Result state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_state <= OUT_IDLE;
      end else begin
         out_state <= out_state_next;
      end
   end

   // Hold a result until consumed; a close in the consuming cycle keeps it held with new data.
   always_comb begin
      out_state_next = out_state;
      case (out_state)
         OUT_IDLE: begin
            if (closing) begin
               out_state_next = OUT_HOLD;
            end
         end
         OUT_HOLD: begin
            if (sad_ready) begin
               out_state_next = closing ? OUT_HOLD : OUT_IDLE;
            end
         end
         default: out_state_next = OUT_IDLE;
      endcase
   end

endmodule
